// File: rtl/lix_skid_buf.sv
// Two-entry elastic buffer with valid/ready handshake on both sides.
// Vacated head/skid storage is written to zero so no stale share word lingers.
module lix_skid_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         i_vld,
    input  logic [W-1:0] i_x,
    output logic         o_rdy,
    output logic         o_vld,
    output logic [W-1:0] o_z,
    input  logic         i_rdy,
    input  logic         i_flush,
    output logic [1:0]   o_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   head_q, head_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           push, pop;

    // Handshakes use the registered flags only, so i_x is ignored without push.
    assign push = i_vld & o_rdy;
    assign pop  = o_vld & i_rdy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = i_x;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = i_x;
                    end else if (push) begin
                        skid_d  = i_x;
                        state_d = FULL;
                    end else if (pop) begin
                        head_d  = '0;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    head_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // Status outputs decode the state register directly; no input reaches them.
    always_comb begin
        o_cnt = state_q;
        o_vld = (state_q == ONE) || (state_q == FULL);
        o_rdy = (state_q != FULL);
        o_z   = head_q;
    end

endmodule

// File: tb/tb_lix_skid_buf.sv
// Directed and random checks of lix_skid_buf against a queue-based model.
module tb_lix_skid_buf;

    localparam int unsigned W = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         i_vld;
    logic [W-1:0] i_x;
    logic         o_rdy;
    logic         o_vld;
    logic [W-1:0] o_z;
    logic         i_rdy;
    logic         i_flush;
    logic [1:0]   o_cnt;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] q[$];

    lix_skid_buf #(.W(W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_vld  (i_vld),
        .i_x    (i_x),
        .o_rdy  (o_rdy),
        .o_vld  (o_vld),
        .o_z    (o_z),
        .i_rdy  (i_rdy),
        .i_flush(i_flush),
        .o_cnt  (o_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] ez;
        int unsigned  n;
        n  = q.size();
        ez = (n > 0) ? q[0] : '0;
        chk({tag, ".cnt"}, W'(o_cnt), W'(n));
        chk({tag, ".vld"}, W'(o_vld), W'(n > 0));
        chk({tag, ".rdy"}, W'(o_rdy), W'(n < 2));
        chk({tag, ".z"},   o_z,       ez);
    endtask

    // Apply inputs for one cycle, advance the model by the handshake rules,
    // then compare just after the edge.
    task automatic step(input string tag, input logic v, input logic [W-1:0] x,
                        input logic r, input logic f);
        logic do_push, do_pop;
        i_vld   = v;
        i_x     = x;
        i_rdy   = r;
        i_flush = f;
        do_push = v && (q.size() < 2);
        do_pop  = r && (q.size() > 0);
        @(posedge clk_i);
        if (f) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(x);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_ni  = 1'b0;
        i_vld   = 1'b0;
        i_x     = '0;
        i_rdy   = 1'b0;
        i_flush = 1'b0;
        #12;
        check_all("reset");
        rst_ni = 1'b1;

        // Streaming at one word per cycle
        step("s1", 1'b1, 32'h11, 1'b1, 1'b0);
        step("s2", 1'b1, 32'h22, 1'b1, 1'b0);
        step("s3", 1'b1, 32'h33, 1'b1, 1'b0);
        step("s4", 1'b0, 32'h0,  1'b1, 1'b0);

        // Back-pressure, ignored push while full, drain
        step("b1", 1'b1, 32'hA5, 1'b0, 1'b0);
        step("b2", 1'b1, 32'h5A, 1'b0, 1'b0);
        step("b3", 1'b1, 32'hFF, 1'b0, 1'b0);
        step("b4", 1'b0, 32'h0,  1'b1, 1'b0);
        step("b5", 1'b0, 32'h0,  1'b1, 1'b0);
        step("b6", 1'b0, 32'h0,  1'b1, 1'b0);

        // Flush while full with simultaneous pop request
        step("f1", 1'b1, 32'h77, 1'b0, 1'b0);
        step("f2", 1'b1, 32'h88, 1'b0, 1'b0);
        step("f3", 1'b1, 32'h99, 1'b1, 1'b1);
        step("f4", 1'b1, 32'hAB, 1'b0, 1'b0);
        step("f5", 1'b0, 32'h0,  1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle
        step("r1", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        i_vld = 1'b0;
        #3;
        rst_ni = 1'b0;
        q.delete();
        #1;
        check_all("r2");
        @(negedge clk_i);
        rst_ni = 1'b1;
        step("r3", 1'b1, 32'h1, 1'b0, 1'b0);
        step("r4", 1'b0, 32'h0, 1'b1, 1'b0);

        // Random handshake traffic
        for (int i = 0; i < 10000; i++) begin
            step("rnd", 1'($urandom), W'($urandom), 1'($urandom),
                 ($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
